// File: rtl/idli_sqi_ctrl_m_if.sv
// ---------------------------------------------------------------------------
// idli_sqi_ctrl_m_if
//   Bundles the request/response handshake and the SQI memory pins of the
//   idli_sqi_ctrl_m quad-SPI controller.
//   master : request issuer (drives req_*, sees rdy and responses)
//   slave  : controller side (accepts requests, drives the memory pins)
//   mem    : external memory model side (sees SCK/CS/SIO, returns sio_i)
// ---------------------------------------------------------------------------
interface idli_sqi_ctrl_m_if;
  logic        req_vld;
  logic        req_rdy;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_data;
  logic        rsp_vld;
  logic [15:0] rsp_data;
  logic        mem_sck;
  logic        mem_cs;
  logic        mem_en;
  logic [3:0]  mem_sio_o;
  logic [3:0]  mem_sio_i;

  modport master (output req_vld, req_wr, req_addr, req_data,
                  input  req_rdy, rsp_vld, rsp_data);
  modport slave  (input  req_vld, req_wr, req_addr, req_data, mem_sio_i,
                  output req_rdy, rsp_vld, rsp_data,
                         mem_sck, mem_cs, mem_en, mem_sio_o);
  modport mem    (input  mem_sck, mem_cs, mem_en, mem_sio_o,
                  output mem_sio_i);
endinterface

// File: rtl/idli_sqi_ctrl_m.sv
// ---------------------------------------------------------------------------
// idli_sqi_ctrl_m
//   Quad-SPI (SQI) memory controller. One 16-bit word per request:
//   CMD (2 nibbles: 0x03 read / 0x02 write), ADDR (6 nibbles of byte
//   address), DUMMY (reads only, DUMMY_NIBBLES slots), DATA (4 nibbles),
//   then a one-cycle DONE carrying rsp_vld. Every nibble slot is two
//   cycles: SCK low while SIO changes, SCK high, sample at the end.
//
//   Ports
//     i_ctl_gck / i_ctl_rst_n   clock, async active-low reset
//     i_ctl_req_*/o_ctl_req_rdy request handshake (wr, word addr, data)
//     o_ctl_rsp_vld/_data       completion pulse and read data
//     o_ctl_mem_sck/_cs/_en     memory clock, select (low), SIO drive enable
//     o_ctl_mem_sio/i_ctl_mem_sio  SIO nibble out / in
//
//   Build option IDLI_SQI_CTRL_BURST_EN: adds a HOLD state after DATA that
//   keeps CS low and accepts a same-direction request to the next word,
//   continuing straight into DATA.
// ---------------------------------------------------------------------------
package idli_sqi_pkg;
  typedef logic [3:0] slice_t;
endpackage

module idli_sqi_ctrl_m
  import idli_sqi_pkg::*;
#(
  parameter int unsigned DUMMY_NIBBLES = 2
) (
  input  logic        i_ctl_gck,
  input  logic        i_ctl_rst_n,
  input  logic        i_ctl_req_vld,
  output logic        o_ctl_req_rdy,
  input  logic        i_ctl_req_wr,
  input  logic [15:0] i_ctl_req_addr,
  input  logic [15:0] i_ctl_req_data,
  output logic        o_ctl_rsp_vld,
  output logic [15:0] o_ctl_rsp_data,
  output logic        o_ctl_mem_sck,
  output logic        o_ctl_mem_cs,
  output slice_t      o_ctl_mem_sio,
  input  slice_t      i_ctl_mem_sio,
  output logic        o_ctl_mem_en
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE, S_HOLD
  } state_e;

  localparam logic [2:0] DUM_LAST =
    (DUMMY_NIBBLES == 0) ? 3'd0 : 3'(DUMMY_NIBBLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;      // nibble slot within the current state
  logic        ph_q, ph_d;        // 0: SCK low / drive, 1: SCK high / sample
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        live_q, live_d;    // keeps rdy low while reset is applied

  logic        in_slot, slot_last, rdy, accept;
  logic [7:0]  cmd;
  logic [23:0] baddr;

  always_ff @(posedge i_ctl_gck or negedge i_ctl_rst_n) begin
    if (!i_ctl_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ph_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ph_q       <= ph_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      live_q     <= live_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ph_d       = ph_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    live_d     = 1'b1;

    in_slot = (state_q == S_CMD) || (state_q == S_ADDR) ||
              (state_q == S_DUMMY) || (state_q == S_DATA);

    rdy = live_q && (state_q == S_IDLE);
`ifdef IDLI_SQI_CTRL_BURST_EN
    // Burst continuation: same direction, next word, no address wrap.
    if (state_q == S_HOLD)
      rdy = live_q && i_ctl_req_vld && (i_ctl_req_wr == wr_q) &&
            (i_ctl_req_addr == addr_q + 16'd1) && (addr_q != 16'hFFFF);
`endif
    accept = rdy && i_ctl_req_vld;

    case (state_q)
      S_CMD:   slot_last = (cnt_q == 3'd1);
      S_ADDR:  slot_last = (cnt_q == 3'd5);
      S_DUMMY: slot_last = (cnt_q == DUM_LAST);
      S_DATA:  slot_last = (cnt_q == 3'd3);
      default: slot_last = 1'b0;
    endcase

    if (in_slot) begin
      ph_d = ~ph_q;
      if (ph_q) cnt_d = slot_last ? 3'd0 : cnt_q + 3'd1;
    end

    case (state_q)
      S_IDLE: if (accept) begin
        wr_d    = i_ctl_req_wr;
        addr_d  = i_ctl_req_addr;
        data_d  = i_ctl_req_data;
        cnt_d   = '0;
        ph_d    = 1'b0;
        state_d = S_CMD;
      end
      S_CMD:   if (ph_q && slot_last) state_d = S_ADDR;
      S_ADDR:  if (ph_q && slot_last)
                 state_d = (!wr_q && DUMMY_NIBBLES != 0) ? S_DUMMY : S_DATA;
      S_DUMMY: if (ph_q && slot_last) state_d = S_DATA;
      S_DATA: begin
        if (ph_q && !wr_q) rsp_data_d = {rsp_data_q[11:0], i_ctl_mem_sio};
`ifdef IDLI_SQI_CTRL_BURST_EN
        if (ph_q && slot_last) state_d = S_HOLD;
`else
        if (ph_q && slot_last) state_d = S_DONE;
`endif
      end
      S_DONE: state_d = S_IDLE;
`ifdef IDLI_SQI_CTRL_BURST_EN
      S_HOLD: if (accept) begin
        addr_d  = i_ctl_req_addr;
        data_d  = i_ctl_req_data;
        cnt_d   = '0;
        ph_d    = 1'b0;
        state_d = S_DATA;
      end else begin
        state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd   = {7'b0000001, ~wr_q};
  assign baddr = {7'b0, addr_q, 1'b0};

  // SIO output nibble, MSB first within each field; 0 whenever not driving.
  always_comb begin
    o_ctl_mem_sio = '0;
    case (state_q)
      S_CMD:   o_ctl_mem_sio = cnt_q[0] ? cmd[3:0] : cmd[7:4];
      S_ADDR:  o_ctl_mem_sio = slice_t'(baddr >> {3'd5 - cnt_q, 2'b00});
      S_DATA:  if (wr_q)
                 o_ctl_mem_sio = slice_t'(data_q >> {2'd3 - cnt_q[1:0], 2'b00});
      default: ;
    endcase
  end

  assign o_ctl_req_rdy  = rdy;
  assign o_ctl_mem_sck  = in_slot && ph_q;
  assign o_ctl_mem_cs   = !(in_slot || (state_q == S_HOLD));
  assign o_ctl_mem_en   = (state_q == S_CMD) || (state_q == S_ADDR) ||
                          ((state_q == S_DATA) && wr_q);
  assign o_ctl_rsp_vld  = (state_q == S_DONE) || (state_q == S_HOLD);
  assign o_ctl_rsp_data = rsp_data_q;

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// ---------------------------------------------------------------------------
// tb_idli_sqi_ctrl_m
//   Directed bench for idli_sqi_ctrl_m with a behavioural SQI memory that
//   decodes CMD/ADDR, stores write data and returns read data. A second
//   instance with DUMMY_NIBBLES=0 reads a constant SIO pattern.
// ---------------------------------------------------------------------------
module tb_idli_sqi_ctrl_m;
  localparam int DN = 2;

  logic gclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 gclk = ~gclk;

  idli_sqi_ctrl_m_if bus();

  idli_sqi_ctrl_m #(.DUMMY_NIBBLES(DN)) dut (
    .i_ctl_gck(gclk), .i_ctl_rst_n(rst_n),
    .i_ctl_req_vld(bus.req_vld), .o_ctl_req_rdy(bus.req_rdy),
    .i_ctl_req_wr(bus.req_wr), .i_ctl_req_addr(bus.req_addr),
    .i_ctl_req_data(bus.req_data),
    .o_ctl_rsp_vld(bus.rsp_vld), .o_ctl_rsp_data(bus.rsp_data),
    .o_ctl_mem_sck(bus.mem_sck), .o_ctl_mem_cs(bus.mem_cs),
    .o_ctl_mem_sio(bus.mem_sio_o), .i_ctl_mem_sio(bus.mem_sio_i),
    .o_ctl_mem_en(bus.mem_en));

  // zero-dummy instance
  logic        z_vld, z_rdy, z_rsp_vld, z_sck, z_cs, z_en;
  logic [15:0] z_rsp_data;
  logic [3:0]  z_sio_o;
  idli_sqi_ctrl_m #(.DUMMY_NIBBLES(0)) dut_z (
    .i_ctl_gck(gclk), .i_ctl_rst_n(rst_n),
    .i_ctl_req_vld(z_vld), .o_ctl_req_rdy(z_rdy),
    .i_ctl_req_wr(1'b0), .i_ctl_req_addr(16'h0100),
    .i_ctl_req_data(16'h0000),
    .o_ctl_rsp_vld(z_rsp_vld), .o_ctl_rsp_data(z_rsp_data),
    .o_ctl_mem_sck(z_sck), .o_ctl_mem_cs(z_cs),
    .o_ctl_mem_sio(z_sio_o), .i_ctl_mem_sio(4'hA),
    .o_ctl_mem_en(z_en));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- SQI memory model ----------------
  logic [15:0] mem [0:65535];
  int          slot = 0;
  logic [7:0]  s_cmd = 8'h00;
  logic [23:0] s_baddr = '0;
  logic [3:0]  drv_q[$];   // nibbles seen with en=1
  logic        en_log[$];  // en value per slot

  function automatic logic [15:0] wa(input logic [23:0] ba, input int k);
    return ba[16:1] + 16'(k / 4);
  endfunction
  function automatic logic [15:0] put_nib(input logic [15:0] w, input int k, input logic [3:0] n);
    logic [15:0] r;
    r = w;
    r[(3 - k % 4) * 4 +: 4] = n;
    return r;
  endfunction

  always @(posedge gclk) begin
    if (bus.mem_cs) slot <= 0;
    else if (bus.mem_sck) begin
      slot <= slot + 1;
      en_log.push_back(bus.mem_en);
      if (bus.mem_en) drv_q.push_back(bus.mem_sio_o);
      if (slot < 2) s_cmd <= {s_cmd[3:0], bus.mem_sio_o};
      else if (slot < 8) s_baddr <= {s_baddr[19:0], bus.mem_sio_o};
      else if (s_cmd == 8'h02)
        mem[wa(s_baddr, slot - 8)] <= put_nib(mem[wa(s_baddr, slot - 8)], slot - 8, bus.mem_sio_o);
    end
  end

  always_comb begin
    bus.mem_sio_i = 4'h0;
    if (!bus.mem_cs && s_cmd == 8'h03 && slot >= 8 + DN)
      bus.mem_sio_i = mem[wa(s_baddr, slot - 8 - DN)][(3 - (slot - 8 - DN) % 4) * 4 +: 4];
  end

  // ---------------- helpers ----------------
  task automatic txn(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                     output int lat, output logic [15:0] rd);
    bit got;
    drv_q.delete();
    en_log.delete();
    lat = -1;
    rd  = 16'hxxxx;
    got = 0;
    @(negedge gclk);
    bus.req_vld = 1'b1; bus.req_wr = wr; bus.req_addr = addr; bus.req_data = data;
    for (int i = 0; i < 100; i++) begin
      if (bus.req_rdy) begin got = 1; break; end
      @(negedge gclk);
    end
    if (!got) begin bus.req_vld = 1'b0; return; end
    @(posedge gclk);
    @(negedge gclk);
    bus.req_vld = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (bus.rsp_vld) begin lat = c; rd = bus.rsp_data; break; end
      @(negedge gclk);
    end
  endtask

  function automatic logic [47:0] pack_nibs();
    logic [47:0] a = '0;
    foreach (drv_q[j]) a = {a[43:0], drv_q[j]};
    return a;
  endfunction
  function automatic logic [31:0] pack_en();
    logic [15:0] e = '0;
    foreach (en_log[j]) e = {e[14:0], en_log[j]};
    return {16'(en_log.size()), e};
  endfunction

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    int          exp_lat;
    logic [15:0] exp_rd;   // writes: rsp_data must still hold the last read
    logic [47:0] exp_nib;  // driven nibbles (en=1), first in MSB
    logic [31:0] exp_en;   // {slot count, en bit per slot}
  } vec_t;

  localparam logic [31:0] EN_RD = {16'd14, 16'h3FC0};
  localparam logic [31:0] EN_WR = {16'd12, 16'h0FFF};

  initial begin
    vec_t v[10];
    int lat;
    logic [15:0] rd;
    int bad;

    v[0] = '{1'b1, 16'h0012, 16'hBEEF, 25, 16'h0000, 48'h02000024BEEF, EN_WR};
    v[1] = '{1'b0, 16'h0012, 16'h0000, 29, 16'hBEEF, 48'h000003000024, EN_RD};
    v[2] = '{1'b1, 16'h8000, 16'h1234, 25, 16'hBEEF, 48'h020100001234, EN_WR};
    v[3] = '{1'b0, 16'h8000, 16'h0000, 29, 16'h1234, 48'h000003010000, EN_RD};
    v[4] = '{1'b1, 16'h0001, 16'hA5A5, 25, 16'h1234, 48'h02000002A5A5, EN_WR};
    v[5] = '{1'b0, 16'h0001, 16'h0000, 29, 16'hA5A5, 48'h000003000002, EN_RD};
    v[6] = '{1'b1, 16'hFFFF, 16'h0F0F, 25, 16'hA5A5, 48'h0201FFFE0F0F, EN_WR};
    v[7] = '{1'b0, 16'hFFFF, 16'h0000, 29, 16'h0F0F, 48'h00000301FFFE, EN_RD};
    v[8] = '{1'b1, 16'h0000, 16'h5AC3, 25, 16'h0F0F, 48'h020000005AC3, EN_WR};
    v[9] = '{1'b0, 16'h0000, 16'h0000, 29, 16'h5AC3, 48'h000003000000, EN_RD};

    bus.req_vld = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0; bus.req_data = '0;
    z_vld = 1'b0;

    // reset state
    #1;
    chk("rst_cs",   {47'b0, bus.mem_cs},  48'd1);
    chk("rst_sck",  {47'b0, bus.mem_sck}, 48'd0);
    chk("rst_en",   {47'b0, bus.mem_en},  48'd0);
    chk("rst_rdy",  {47'b0, bus.req_rdy}, 48'd0);
    chk("rst_rvld", {47'b0, bus.rsp_vld}, 48'd0);
    chk("rst_rdat", {32'b0, bus.rsp_data}, 48'd0);
    chk("rst_sio",  {44'b0, bus.mem_sio_o}, 48'd0);
    repeat (3) @(negedge gclk);
    rst_n = 1'b1;

    // table vectors
    for (int i = 0; i < 10; i++) begin
      txn(v[i].wr, v[i].addr, v[i].data, lat, rd);
      chk($sformatf("v%0d_lat", i), 48'(lat), 48'(v[i].exp_lat));
      chk($sformatf("v%0d_rd", i), {32'b0, rd}, {32'b0, v[i].exp_rd});
      chk($sformatf("v%0d_nib", i), pack_nibs(), v[i].exp_nib);
      chk($sformatf("v%0d_en", i), {16'b0, pack_en()}, {16'b0, v[i].exp_en});
    end

    // reset in ADDR phase (cycle 8: ADDR, SCK high)
    @(negedge gclk);
    bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 16'h0012;
    bad = 1;
    for (int i = 0; i < 50; i++) begin
      if (bus.req_rdy) begin bad = 0; break; end
      @(negedge gclk);
    end
    chk("mr_accept", 48'(bad), 48'd0);
    @(posedge gclk);
    @(negedge gclk);
    bus.req_vld = 1'b0;
    repeat (7) @(negedge gclk);
    chk("mr_pre_sck", {47'b0, bus.mem_sck}, 48'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_cs",   {47'b0, bus.mem_cs},  48'd1);
    chk("mr_sck",  {47'b0, bus.mem_sck}, 48'd0);
    chk("mr_en",   {47'b0, bus.mem_en},  48'd0);
    chk("mr_rdy",  {47'b0, bus.req_rdy}, 48'd0);
    chk("mr_rdat", {32'b0, bus.rsp_data}, 48'd0);
    repeat (3) @(negedge gclk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 35; c++) begin
      if (bus.rsp_vld) bad++;
      @(negedge gclk);
    end
    chk("mr_no_rsp", 48'(bad), 48'd0);
    txn(1'b0, 16'h0012, 16'h0000, lat, rd);
    chk("mr_rd_lat", 48'(lat), 48'd29);
    chk("mr_rd_dat", {32'b0, rd}, {32'b0, 16'hBEEF});

    // request held through a transaction: rdy low until IDLE
    @(negedge gclk);
    bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 16'h8000;
    bad = 1;
    for (int i = 0; i < 50; i++) begin
      if (bus.req_rdy) begin bad = 0; break; end
      @(negedge gclk);
    end
    chk("hv_accept", 48'(bad), 48'd0);
    @(posedge gclk);
    @(negedge gclk);
    bus.req_wr = 1'b1; bus.req_addr = 16'h0040; bus.req_data = 16'h7777;
    bad = 0;
    for (int c = 1; c <= 29; c++) begin
      if (bus.req_rdy) bad++;
      if (c == 29) begin
        chk("hv_rsp_vld", {47'b0, bus.rsp_vld}, 48'd1);
        chk("hv_rsp_dat", {32'b0, bus.rsp_data}, {32'b0, 16'h1234});
      end
      @(negedge gclk);
    end
    chk("hv_rdy_low", 48'(bad), 48'd0);
    chk("hv_rdy_idle", {47'b0, bus.req_rdy}, 48'd1);
    @(posedge gclk);
    @(negedge gclk);
    bus.req_vld = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      if (bus.rsp_vld && lat < 0) lat = c;
      else if (bus.rsp_vld) bad++;
      @(negedge gclk);
    end
    chk("hv2_lat", 48'(lat), 48'd25);
    chk("hv2_once", 48'(bad), 48'd0);
    txn(1'b0, 16'h0040, 16'h0000, lat, rd);
    chk("hv2_rdback", {32'b0, rd}, {32'b0, 16'h7777});

    // zero-dummy instance: DATA directly after ADDR
    @(negedge gclk);
    z_vld = 1'b1;
    bad = 1;
    for (int i = 0; i < 50; i++) begin
      if (z_rdy) begin bad = 0; break; end
      @(negedge gclk);
    end
    chk("z_accept", 48'(bad), 48'd0);
    @(posedge gclk);
    @(negedge gclk);
    z_vld = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      if (z_rsp_vld) begin lat = c; rd = z_rsp_data; break; end
      @(negedge gclk);
    end
    chk("z_lat", 48'(lat), 48'd25);
    chk("z_dat", {32'b0, rd}, {32'b0, 16'hAAAA});

`ifdef IDLI_SQI_CTRL_BURST_EN
    txn(1'b1, 16'h0004, 16'h1111, lat, rd);
    txn(1'b1, 16'h0005, 16'h2222, lat, rd);
    // burst 0004 -> 0005
    @(negedge gclk);
    bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 16'h0004;
    for (int i = 0; i < 50; i++) begin
      if (bus.req_rdy) break;
      @(negedge gclk);
    end
    @(posedge gclk);
    @(negedge gclk);
    bus.req_addr = 16'h0005;
    for (int c = 1; c < 29; c++) @(negedge gclk);
    chk("b_hold_vld", {47'b0, bus.rsp_vld}, 48'd1);
    chk("b_hold_dat", {32'b0, bus.rsp_data}, {32'b0, 16'h1111});
    chk("b_hold_rdy", {47'b0, bus.req_rdy}, 48'd1);
    @(posedge gclk);
    @(negedge gclk);
    bus.req_vld = 1'b0;
    bad = 0;
    for (int c = 1; c < 9; c++) begin
      if (bus.mem_cs) bad++;
      @(negedge gclk);
    end
    chk("b_cs_low", 48'(bad), 48'd0);
    chk("b2_vld", {47'b0, bus.rsp_vld}, 48'd1);
    chk("b2_dat", {32'b0, bus.rsp_data}, {32'b0, 16'h2222});
    // no burst across the top of the address space
    @(negedge gclk);
    bus.req_vld = 1'b1; bus.req_addr = 16'hFFFF;
    for (int i = 0; i < 50; i++) begin
      if (bus.req_rdy) break;
      @(negedge gclk);
    end
    @(posedge gclk);
    @(negedge gclk);
    bus.req_addr = 16'h0000;
    for (int c = 1; c < 29; c++) @(negedge gclk);
    chk("bw_hold_rdy", {47'b0, bus.req_rdy}, 48'd0);
    @(negedge gclk);
    chk("bw_cs_high", {47'b0, bus.mem_cs}, 48'd1);
    chk("bw_idle_rdy", {47'b0, bus.req_rdy}, 48'd1);
    @(posedge gclk);
    @(negedge gclk);
    bus.req_vld = 1'b0;
    repeat (35) @(negedge gclk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
